// File: rtl/btn_sync_pkg.sv
// Shared types and clocking constants for the push-button input path.
// Used by btn_debouncer and any other block that conditions a pad input.
package btn_sync_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW     = 2'd0,
      CONFIRM_HIGH = 2'd1,
      IDLE_HIGH    = 2'd2,
      CONFIRM_LOW  = 2'd3
   } btn_state_t;

   localparam int SYS_CLK_HZ          = 125_000_000;
   localparam int DEBOUNCE_MS_DEFAULT = 10;

   // Confirm window length in SYS_CLK cycles for a given debounce time.
   function automatic int debounce_cycles(input int ms);
      return (SYS_CLK_HZ / 1000) * ms;
   endfunction

endpackage : btn_sync_pkg

// File: rtl/sig_sync.sv
// N-stage flop synchroniser with asynchronous active-high reset, for bringing
// asynchronous pad inputs into a clock domain. STAGES must be 2 or more.
module sig_sync #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sig_in,
   output logic [WIDTH-1:0] sig_out
);

   // Placement tools keep these flops adjacent to maximise metastability settling time.
   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= sig_in;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sig_out = sync_q[STAGES-1];

endmodule : sig_sync

// File: rtl/btn_debouncer.sv
// Push-button conditioner: synchroniser, confirm-counter debounce FSM, edge pulses.
// Optional macro BTN_LED_TOGGLE_EN builds a press-toggled LED flop; otherwise LED_TOGGLE = BTN_LEVEL.
module btn_debouncer
   import btn_sync_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = debounce_cycles(DEBOUNCE_MS_DEFAULT)
) (
   input  logic SYS_CLK,
   input  logic SYS_RST,
   input  logic BTN_IN,
   output logic BTN_LEVEL,
   output logic BTN_RISE,
   output logic BTN_FALL,
   output logic LED_TOGGLE
);

   localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             btn_s;
   btn_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             level_q;
   logic             rise_q;
   logic             fall_q;
`ifdef BTN_LED_TOGGLE_EN
   logic             led_q;
`endif

   sig_sync #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (1)
   ) u_btn_sync (
      .clk     (SYS_CLK),
      .rst     (SYS_RST),
      .sig_in  (BTN_IN),
      .sig_out (btn_s)
   );

   // Any disagreement with the candidate level during CONFIRM restarts the whole window.
   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         state   <= IDLE_LOW;
         cnt     <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
`ifdef BTN_LED_TOGGLE_EN
         led_q   <= 1'b0;
`endif
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         unique case (state)
            IDLE_LOW: begin
               if (btn_s) begin
                  state <= CONFIRM_HIGH;
                  cnt   <= '0;
               end
            end
            CONFIRM_HIGH: begin
               if (!btn_s) begin
                  state <= IDLE_LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  state   <= IDLE_HIGH;
                  cnt     <= '0;
                  level_q <= 1'b1;
                  rise_q  <= 1'b1;
`ifdef BTN_LED_TOGGLE_EN
                  led_q   <= ~led_q;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            IDLE_HIGH: begin
               if (!btn_s) begin
                  state <= CONFIRM_LOW;
                  cnt   <= '0;
               end
            end
            CONFIRM_LOW: begin
               if (btn_s) begin
                  state <= IDLE_HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  state   <= IDLE_LOW;
                  cnt     <= '0;
                  level_q <= 1'b0;
                  fall_q  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE_LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign BTN_LEVEL = level_q;
   assign BTN_RISE  = rise_q;
   assign BTN_FALL  = fall_q;
`ifdef BTN_LED_TOGGLE_EN
   assign LED_TOGGLE = led_q;
`else
   assign LED_TOGGLE = level_q;
`endif

endmodule : btn_debouncer

// File: tb/tb_btn_debouncer.sv
// Directed testbench for btn_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=8.
// LED expectations follow BTN_LED_TOGGLE_EN when it is defined for the build.
module tb_btn_debouncer;

   logic SYS_CLK;
   logic SYS_RST;
   logic BTN_IN;
   logic BTN_LEVEL;
   logic BTN_RISE;
   logic BTN_FALL;
   logic LED_TOGGLE;

   int   n_checks = 0;
   int   n_errors = 0;
   logic led_m    = 1'b0;

   btn_debouncer #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .SYS_CLK    (SYS_CLK),
      .SYS_RST    (SYS_RST),
      .BTN_IN     (BTN_IN),
      .BTN_LEVEL  (BTN_LEVEL),
      .BTN_RISE   (BTN_RISE),
      .BTN_FALL   (BTN_FALL),
      .LED_TOGGLE (LED_TOGGLE)
   );

   initial SYS_CLK = 1'b0;
   always #5 SYS_CLK = ~SYS_CLK;

   function automatic logic [3:0] outs();
      return {BTN_LEVEL, BTN_RISE, BTN_FALL, LED_TOGGLE};
   endfunction

   function automatic logic [3:0] ev(input logic lvl, input logic r, input logic f);
`ifdef BTN_LED_TOGGLE_EN
      return {lvl, r, f, led_m};
`else
      return {lvl, r, f, lvl};
`endif
   endfunction

   task automatic step();
      @(posedge SYS_CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed {lvl,rise,fall,led}=%b expected=%b", tag, obs, exp);
      end
   endtask

   // n cycles with no output activity at the given level
   task automatic quiet(input string tag, input int n, input logic lvl);
      for (int i = 0; i < n; i++) begin
         step();
         chk(tag, outs(), ev(lvl, 1'b0, 1'b0));
      end
   endtask

   // Called right after BTN_IN changes: outputs must hold for edges 0..9 and move at edge 10.
   task automatic transition(input string tag, input logic new_lvl);
      quiet({tag, "_wait"}, 10, ~new_lvl);
      step();
      if (new_lvl) led_m = ~led_m;
      chk({tag, "_edge"}, outs(), ev(new_lvl, new_lvl, ~new_lvl));
      step();
      chk({tag, "_after"}, outs(), ev(new_lvl, 1'b0, 1'b0));
   endtask

   initial begin
      SYS_RST = 1'b1;
      BTN_IN  = 1'bx;
      repeat (3) step();
      chk("rst_btn_x", outs(), 4'b0000);
      BTN_IN = 1'b1;
      repeat (2) step();
      chk("rst_btn_1", outs(), 4'b0000);
      BTN_IN = 1'b0;
      step();
      SYS_RST = 1'b0;
      quiet("idle_after_rst", 50, 1'b0);

      // Clean press
      BTN_IN = 1'b1;
      transition("press1", 1'b1);
      quiet("press1_hold", 20, 1'b1);

      // 5-cycle low glitch on a held button
      BTN_IN = 1'b0;
      quiet("glitch_low", 5, 1'b1);
      BTN_IN = 1'b1;
      quiet("glitch_low_after", 20, 1'b1);

      // Release
      BTN_IN = 1'b0;
      transition("release1", 1'b0);
      quiet("release1_hold", 20, 1'b0);

      // 5-cycle high glitch on a released button
      BTN_IN = 1'b1;
      quiet("glitch_high", 5, 1'b0);
      BTN_IN = 1'b0;
      quiet("glitch_high_after", 20, 1'b0);

      // Second press toggles the LED back
      BTN_IN = 1'b1;
      transition("press2", 1'b1);
      quiet("press2_hold", 5, 1'b1);
      BTN_IN = 1'b0;
      transition("release2", 1'b0);
      quiet("release2_hold", 10, 1'b0);

      // Bounce: toggle every 3 cycles for 30 cycles, then hold high
      for (int seg = 0; seg < 10; seg++) begin
         BTN_IN = (seg % 2 == 0) ? 1'b1 : 1'b0;
         quiet("bounce", 3, 1'b0);
      end
      BTN_IN = 1'b1;
      transition("bounce_settle", 1'b1);
      quiet("bounce_hold", 20, 1'b1);

      // Reset while in CONFIRM_HIGH with cnt=4
      BTN_IN = 1'b0;
      transition("release3", 1'b0);
      quiet("release3_hold", 5, 1'b0);
      BTN_IN = 1'b1;
      quiet("confirm_fill", 7, 1'b0);
      SYS_RST = 1'b1;
      led_m   = 1'b0;
      #1;
      chk("rst_async_clear", outs(), 4'b0000);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_mid_hold", outs(), 4'b0000);
      end
      SYS_RST = 1'b0;
      transition("rst_press", 1'b1);
      quiet("rst_press_hold", 20, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_btn_debouncer
